// File: rtl/reaction_timer.sv
// reaction_timer: measures ms from lights out to key press,
// flags false starts and timeouts, and tracks the best time.
module reaction_timer #(
  parameter int CNT_W  = 14,
  parameter int MAX_MS = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_ms,
  input  logic             arm,
  input  logic             go,
  input  logic             key_n,
  output logic [CNT_W-1:0] reaction_ms,
  output logic [CNT_W-1:0] best_ms,
  output logic             done,
  output logic             false_start,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_MS);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    TIMING,
    DONE,
    FAULT
  } state_t;

  state_t state;
  logic   sync1;
  logic   sync2;
  logic   hist;
  logic   press;

  // one pulse on each synchronized 1->0 edge of the button
  assign press = hist & ~sync2;

  // two-flop synchronizer plus history flop, idle high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // control FSM; reaction_ms doubles as the running counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      reaction_ms <= '0;
      best_ms     <= MAX;
      done        <= 1'b0;
      false_start <= 1'b0;
      timeout     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            state <= ARMED;
            busy  <= 1'b1;
          end
        end
        ARMED: begin
          if (press) begin
            state       <= FAULT;
            false_start <= 1'b1;
            busy        <= 1'b0;
          end else if (go) begin
            state       <= TIMING;
            reaction_ms <= '0;
          end
        end
        TIMING: begin
          if (press) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            if (reaction_ms < best_ms)
              best_ms <= reaction_ms;
          end else if (tick_ms) begin
            if (reaction_ms == MAX) begin
              state   <= DONE;
              done    <= 1'b1;
              timeout <= 1'b1;
              busy    <= 1'b0;
            end else begin
              reaction_ms <= reaction_ms + 1'b1;
            end
          end
        end
        DONE, FAULT: begin
          if (arm) begin
            state       <= ARMED;
            done        <= 1'b0;
            false_start <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_timer.sv
// tb_reaction_timer: directed scenarios for reaction_timer.
// Inputs change and outputs are sampled on the falling edge.
module tb_reaction_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_ms;
  logic        arm;
  logic        go;
  logic        key_n;
  logic [13:0] reaction_ms;
  logic [13:0] best_ms;
  logic        done;
  logic        false_start;
  logic        timeout;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk = ~clk;

  reaction_timer dut (
    .clk         (clk),
    .rst         (rst),
    .tick_ms     (tick_ms),
    .arm         (arm),
    .go          (go),
    .key_n       (key_n),
    .reaction_ms (reaction_ms),
    .best_ms     (best_ms),
    .done        (done),
    .false_start (false_start),
    .timeout     (timeout),
    .busy        (busy)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    cyc(1);
    arm = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    cyc(1);
    go = 1'b0;
  endtask

  task automatic ticks(input int n);
    tick_ms = 1'b1;
    cyc(n);
    tick_ms = 1'b0;
  endtask

  task automatic press_key();
    key_n = 1'b0;
    cyc(3);
    key_n = 1'b1;
    cyc(3);
  endtask

  task automatic start_run();
    pulse_arm();
    cyc(2);
    pulse_go();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(2);
    n_tests++;
    if (reaction_ms !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_reaction got %0d want 0", reaction_ms);
    end
    n_tests++;
    if (best_ms !== 14'd9999) begin
      n_fail++;
      $display("FAIL reset_best got %0d want 9999", best_ms);
    end
    n_tests++;
    if ({done, false_start, timeout, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 0000",
               {done, false_start, timeout, busy});
    end
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_first_run();
    pulse_arm();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL arm_busy got %b want 1", busy);
    end
    cyc(2);
    pulse_go();
    ticks(250);
    press_key();
    n_tests++;
    if ({done, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL run1_flags got %b want 10", {done, busy});
    end
    n_tests++;
    if (reaction_ms !== 14'd250) begin
      n_fail++;
      $display("FAIL run1_reaction got %0d want 250", reaction_ms);
    end
    n_tests++;
    if (best_ms !== 14'd250) begin
      n_fail++;
      $display("FAIL run1_best got %0d want 250", best_ms);
    end
  endtask

  task automatic test_more_runs();
    start_run();
    ticks(400);
    press_key();
    n_tests++;
    if (reaction_ms !== 14'd400 || best_ms !== 14'd250) begin
      n_fail++;
      $display("FAIL run2 got %0d/%0d want 400/250",
               reaction_ms, best_ms);
    end
    start_run();
    ticks(180);
    press_key();
    n_tests++;
    if (reaction_ms !== 14'd180 || best_ms !== 14'd180) begin
      n_fail++;
      $display("FAIL run3 got %0d/%0d want 180/180",
               reaction_ms, best_ms);
    end
  endtask

  task automatic test_false_start();
    pulse_arm();
    cyc(2);
    press_key();
    n_tests++;
    if ({false_start, done, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL fs_flags got %b want 100",
               {false_start, done, busy});
    end
    n_tests++;
    if (reaction_ms !== 14'd180) begin
      n_fail++;
      $display("FAIL fs_reaction got %0d want 180", reaction_ms);
    end
    pulse_go();
    ticks(5);
    cyc(1);
    n_tests++;
    if ({false_start, done, busy} !== 3'b100 ||
        reaction_ms !== 14'd180) begin
      n_fail++;
      $display("FAIL fs_go_ignored got %b/%0d want 100/180",
               {false_start, done, busy}, reaction_ms);
    end
    pulse_arm();
    n_tests++;
    if ({false_start, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL fs_rearm got %b want 01",
               {false_start, busy});
    end
    key_n = 1'b0;
    cyc(2);
    pulse_go();
    key_n = 1'b1;
    cyc(3);
    n_tests++;
    if ({false_start, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL fs_press_go got %b want 10",
               {false_start, busy});
    end
  endtask

  task automatic test_timeout();
    start_run();
    ticks(9999);
    n_tests++;
    if (reaction_ms !== 14'd9999 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL to_edge got %0d busy=%b done=%b want 9999 1 0",
               reaction_ms, busy, done);
    end
    ticks(1);
    n_tests++;
    if ({done, timeout, busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL to_flags got %b want 110",
               {done, timeout, busy});
    end
    n_tests++;
    if (reaction_ms !== 14'd9999 || best_ms !== 14'd180) begin
      n_fail++;
      $display("FAIL to_values got %0d/%0d want 9999/180",
               reaction_ms, best_ms);
    end
    ticks(3);
    n_tests++;
    if (reaction_ms !== 14'd9999) begin
      n_fail++;
      $display("FAIL to_hold got %0d want 9999", reaction_ms);
    end
  endtask

  task automatic test_press_tick();
    start_run();
    n_tests++;
    if (timeout !== 1'b0 || reaction_ms !== 14'd0) begin
      n_fail++;
      $display("FAIL go_clear got %b/%0d want 0/0",
               timeout, reaction_ms);
    end
    ticks(57);
    key_n = 1'b0;
    cyc(2);
    ticks(1);
    n_tests++;
    if (done !== 1'b1 || reaction_ms !== 14'd57) begin
      n_fail++;
      $display("FAIL press_tick got done=%b %0d want 1 57",
               done, reaction_ms);
    end
    n_tests++;
    if (best_ms !== 14'd57) begin
      n_fail++;
      $display("FAIL press_tick_best got %0d want 57", best_ms);
    end
  endtask

  task automatic test_key_held();
    start_run();
    ticks(10);
    cyc(2);
    n_tests++;
    if ({busy, done, false_start} !== 3'b100 ||
        reaction_ms !== 14'd10) begin
      n_fail++;
      $display("FAIL held got %b/%0d want 100/10",
               {busy, done, false_start}, reaction_ms);
    end
    key_n = 1'b1;
    cyc(3);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL release got busy=%b want 1", busy);
    end
    press_key();
    n_tests++;
    if (done !== 1'b1 || reaction_ms !== 14'd10 ||
        best_ms !== 14'd10) begin
      n_fail++;
      $display("FAIL held_repress got %b/%0d/%0d want 1/10/10",
               done, reaction_ms, best_ms);
    end
  endtask

  task automatic test_mid_reset();
    start_run();
    ticks(20);
    #3 rst = 1'b1;
    #1;
    n_tests++;
    if ({done, false_start, timeout, busy} !== 4'b0000 ||
        reaction_ms !== 14'd0 || best_ms !== 14'd9999) begin
      n_fail++;
      $display("FAIL mid_reset got %b/%0d/%0d want 0000/0/9999",
               {done, false_start, timeout, busy},
               reaction_ms, best_ms);
    end
    cyc(1);
    rst = 1'b0;
    cyc(1);
    pulse_go();
    ticks(5);
    n_tests++;
    if (busy !== 1'b0 || reaction_ms !== 14'd0) begin
      n_fail++;
      $display("FAIL go_no_arm got busy=%b %0d want 0 0",
               busy, reaction_ms);
    end
  endtask

  initial begin
    rst     = 1'b1;
    tick_ms = 1'b0;
    arm     = 1'b0;
    go      = 1'b0;
    key_n   = 1'b1;
    test_reset();
    test_first_run();
    test_more_runs();
    test_false_start();
    test_timeout();
    test_press_tick();
    test_key_held();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reaction_timer.md
# reaction_timer

Measures the player's reaction time, in milliseconds, from "lights out" to key press. It sits on the response side of the starting-line sequence: it is armed when the light sequence begins and started by the random-delay timeout. It counts `tick_ms` enables until KEY is pressed, flags false starts and timeouts, and keeps a best-time register. The binary result drives the 16-bit binary-to-BCD / 7-segment path.

## Interface
Parameters:
- `CNT_W`, 14: width of the millisecond counter and result registers.
- `MAX_MS`, 9999: saturation and timeout value in ms; must be less than 2^CNT_W.

Ports:
- `clk`  in  1  system clock, 50 MHz. One clock domain only.
- `rst`  in  1  asynchronous, active-high reset.
- `tick_ms`  in  1  one-`clk`-cycle enable, once per ms.
- `arm`  in  1  one-cycle pulse when the light sequence starts.
- `go`  in  1  one-cycle pulse at lights out (delay `time_out`).
- `key_n`  in  1  raw, asynchronous, active-low push button.
- `reaction_ms`  out  CNT_W  last result; live count while timing.
- `best_ms`  out  CNT_W  smallest valid result since reset.
- `done`  out  1  high in DONE.
- `false_start`  out  1  high in FAULT.
- `timeout`  out  1  high in DONE when the result saturated.
- `busy`  out  1  high in ARMED or TIMING.

## Operation
- Key input:
  - Two-flop synchronizer on `key_n`, followed by one history flop.
  - `press` is a one-cycle pulse when the synchronized value changes 1→0.
  - Holding the key produces no further pulses.
- States: IDLE, ARMED, TIMING, DONE, FAULT.
  - IDLE --`arm`--> ARMED.
  - ARMED --`press`--> FAULT. `press` has priority over a `go` in the same cycle.
  - ARMED --`go`--> TIMING. The counter clears to 0 on entry.
  - TIMING:
    - on a `tick_ms` cycle with no `press`, the count increments;
    - `press` → DONE, capturing the count before any same-cycle tick (press wins);
    - if the count equals `MAX_MS` and `tick_ms` arrives → DONE with `timeout`=1 and result=`MAX_MS`.
  - DONE / FAULT --`arm`--> ARMED. This clears `done`, `false_start` and `timeout`. `reaction_ms` keeps its old value until `go`.
  - `arm` is ignored in ARMED and TIMING. `go` is ignored outside ARMED. `press` is ignored in IDLE, DONE and FAULT.
- `reaction_ms`:
  - reflects the running counter in TIMING;
  - holds the captured value in DONE;
  - does not change in FAULT.
- `best_ms` updates in the cycle of entry to DONE, only when `timeout`=0 and the captured value is less than `best_ms`. An equal value leaves it unchanged.
- Arithmetic is unsigned CNT_W-bit. The counter never exceeds `MAX_MS` and never wraps.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE;
  - `reaction_ms` = 0;
  - `best_ms` = `MAX_MS`;
  - `done`, `false_start`, `timeout`, `busy` = 0;
  - synchronizer and history flops = 1 (key released).
- `press` latency: the pulse is asserted 3 `clk` edges after `key_n` falls, when `key_n` is stable around the edge.
- All outputs are registered. Flags change on the edge that performs the state transition.
- Example: `press` sampled at edge N → `done`=1 and `reaction_ms` final after edge N; `best_ms` updated after the same edge.
- `busy` rises after the edge sampling `arm`, and falls after the edge entering DONE or FAULT.
- Reset asserted mid-run (ARMED or TIMING): return to IDLE. `best_ms` is reset to `MAX_MS`.
- `go` and `arm` are single-cycle. A multi-cycle `go` counts as a single start, because only the ARMED→TIMING transition acts on it.

## Test plan
- Reset, then `arm`; `go` 3 cycles later; 250 `tick_ms` pulses; then press → `done`=1, `reaction_ms`=250, `best_ms`=250, `busy`=0.
- Second run with 400 ticks → `reaction_ms`=400, `best_ms` stays 250. Third run with 180 ticks → `best_ms`=180.
- `arm`, then press before `go` → `false_start`=1, `reaction_ms` unchanged. A later `go` is ignored and the state stays FAULT. Pressing and `go` in the same cycle also gives FAULT.
- `arm`, `go`, no press for 10000 ticks → `done`=1, `timeout`=1, `reaction_ms`=9999, `best_ms` unchanged.
- Press synchronized in the same cycle as a `tick_ms` with count=57 → captured 57, not 58. Holding the key through the next run gives no false start until it is released and pressed again.
- Assert `rst` asynchronously mid-TIMING → all flags 0 and `reaction_ms`=0 immediately, with `best_ms`=9999. A subsequent `go` without `arm` is ignored.
